// File: rtl/hamming74_serial_tx.sv
// Hamming(7,4) encoder with a UART-style serial transmitter (start, 7 code bits LSB first, stop).
// Optional error injection on the accepted codeword is enabled by defining ERR_INJECT_EN.
module hamming74_serial_tx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] err_pos,
  output logic       tx,
  output logic [6:0] code,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [6:0]    shift;
  logic [6:0]    enc;
  logic [6:0]    mask;
  logic [6:0]    code_acc;
  logic          accept;
  logic          baud_wrap;

  // Hamming position k lives in code[k-1]; parity bits sit at positions 1, 2 and 4.
  always_comb begin
    enc[0] = i[0] ^ i[1] ^ i[3];
    enc[1] = i[0] ^ i[2] ^ i[3];
    enc[2] = i[0];
    enc[3] = i[1] ^ i[2] ^ i[3];
    enc[4] = i[1];
    enc[5] = i[2];
    enc[6] = i[3];
  end

`ifdef ERR_INJECT_EN
  always_comb begin
    mask = 7'h00;
    if (err_pos != 3'd0)
      mask = 7'(7'd1 << (err_pos - 3'd1));
  end
`else
  logic unused_err_pos;
  assign unused_err_pos = ^err_pos;
  assign mask           = 7'h00;
`endif

  assign code_acc  = enc ^ mask;
  assign accept    = in_valid && in_ready;
  assign baud_wrap = (baud == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= 3'd0;
      shift    <= 7'h00;
      code     <= 7'h00;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            code     <= code_acc;
            shift    <= code_acc;
            tx       <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            baud     <= '0;
            bit_idx  <= 3'd0;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud  <= '0;
            state <= DATA;
            tx    <= shift[0];
          end else begin
            baud <= baud + CW'(1);
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud <= '0;
            if (bit_idx == 3'd6) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + CW'(1);
          end
        end
        STOP: begin
          // done is registered, so it is raised one cycle early to land on the final stop cycle.
          if (baud == PRE_LAST)
            done <= 1'b1;
          if (baud_wrap) begin
            baud     <= '0;
            bit_idx  <= 3'd0;
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
